sseg_disp_arb: RTL

//  Time-shares the single univ_sseg display between two result sources (A, B), e.g. two
//  mag5b_comp channels. Non-preemptive round-robin arbiter with a fixed dwell time.

---
 rtl/sseg_disp_arb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sseg_disp_arb.sv
// ---------------------------------------------------------------------------
// sseg_disp_arb
//   Time-shares one univ_sseg display between two result sources (A and B).
//   Non-preemptive round-robin arbiter with a fixed dwell time. On each grant
//   the granted source's magnitude/sign/valid is snapshotted and held on the
//   display for DWELL cycles. univ_sseg keeps its own digit-mux clock.
//
// Parameters
//   DW     width of cnt_a / cnt_b / cnt1
//   DWELL  cycles each grant is displayed (>= 1)
//   CNT_W  dwell counter width, 2**CNT_W > DWELL-1
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_a/req_b               level display requests
//   cnt_x/sign_x/valid_x      source result fields (sampled only on grant)
//   gnt_a/gnt_b               source whose snapshot is on the display
//   done_a/done_b             1-cycle pulse when that source's dwell ends
//   cnt1/sign/valid           snapshot driven to univ_sseg
//   busy                      a grant is active
// ---------------------------------------------------------------------------
module sseg_disp_arb #(
  parameter int DW    = 8,
  parameter int DWELL = 50_000_000,
  parameter int CNT_W = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic [DW-1:0] cnt_a,
  input  logic          sign_a,
  input  logic          valid_a,
  input  logic          req_b,
  input  logic [DW-1:0] cnt_b,
  input  logic          sign_b,
  input  logic          valid_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          done_a,
  output logic          done_b,
  output logic [DW-1:0] cnt1,
  output logic          sign,
  output logic          valid,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_t;
  typedef enum logic {SRC_A, SRC_B} src_t;

  localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(DWELL - 1);

  state_t           r_state, w_state_nxt;
  src_t             r_last, w_last_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0]    r_cnt1, w_cnt1_nxt;
  logic             r_sign, w_sign_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_gnt_a, r_gnt_b, r_busy;
  logic             r_done_a, r_done_b, w_done_a_nxt, w_done_b_nxt;
  logic             w_eval;

  // Arbitration happens from IDLE, or on the very edge the dwell expires so
  // back-to-back grants have no idle gap.
  assign w_eval = (r_state == IDLE) || (r_cnt == '0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    w_state_nxt  = r_state;
    w_last_nxt   = r_last;
    w_cnt_nxt    = r_cnt;
    w_cnt1_nxt   = r_cnt1;
    w_sign_nxt   = r_sign;
    w_valid_nxt  = r_valid;
    w_done_a_nxt = 1'b0;
    w_done_b_nxt = 1'b0;

    if (r_state != IDLE && r_cnt != '0)
      w_cnt_nxt = r_cnt - 1'b1;

    if (r_state == SHOW_A && r_cnt == '0) w_done_a_nxt = 1'b1;
    if (r_state == SHOW_B && r_cnt == '0) w_done_b_nxt = 1'b1;

    if (w_eval) begin
      w_state_nxt = IDLE;
      // A wins if it is the only requester or if B was shown last.
      if (req_a && (!req_b || r_last == SRC_B)) begin
        w_state_nxt = SHOW_A;
        w_last_nxt  = SRC_A;
        w_cnt_nxt   = LP_LOAD;
        w_cnt1_nxt  = cnt_a;
        w_sign_nxt  = sign_a;
        w_valid_nxt = valid_a;
      end else if (req_b) begin
        w_state_nxt = SHOW_B;
        w_last_nxt  = SRC_B;
        w_cnt_nxt   = LP_LOAD;
        w_cnt1_nxt  = cnt_b;
        w_sign_nxt  = sign_b;
        w_valid_nxt = valid_b;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= SRC_B;
      r_cnt    <= '0;
      r_cnt1   <= '0;
      r_sign   <= 1'b0;
      r_valid  <= 1'b0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_busy   <= 1'b0;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cnt1   <= w_cnt1_nxt;
      r_sign   <= w_sign_nxt;
      r_valid  <= w_valid_nxt;
      r_gnt_a  <= (w_state_nxt == SHOW_A);
      r_gnt_b  <= (w_state_nxt == SHOW_B);
      r_busy   <= (w_state_nxt != IDLE);
      r_done_a <= w_done_a_nxt;
      r_done_b <= w_done_b_nxt;
    end
  end

  assign gnt_a  = r_gnt_a;
  assign gnt_b  = r_gnt_b;
  assign busy   = r_busy;
  assign done_a = r_done_a;
  assign done_b = r_done_b;
  assign cnt1   = r_cnt1;
  assign sign   = r_sign;
  assign valid  = r_valid;

endmodule
